// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default sizing for the down timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_timer_if.sv
// rtl/down_timer_if.sv - control/status bundle between a timer user and the down timer
interface down_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             irq;
    logic             ovf;

    modport master (
        output load, load_value, start, stop, auto_reload, irq_ack,
        input  count, busy, done, irq, ovf
    );

    modport slave (
        input  load, load_value, start, stop, auto_reload, irq_ack,
        output count, busy, done, irq, ovf
    );

endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides clk into one tick every PRESCALE enabled cycles
module timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // A clear suppresses the tick so a same-cycle load or stop wins over it.
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (enable && !clear) begin
            tick  = (cnt_q == LAST);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - prescaled down counter with IDLE/RUN/DONE control, auto-reload and sticky irq/ovf
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic         clk,
    input  logic         rst,
    down_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             expire;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.load | bus.stop),
        .enable (state_q == RUN),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire   = 1'b0;
        if (bus.load) begin
            reload_d = bus.load_value;
            count_d  = bus.load_value;
            if (bus.start && state_q != RUN && bus.load_value != '0) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (bus.stop) begin
                state_d = IDLE;
            end else if (tick && count_q == ONE) begin
                expire = 1'b1;
                if (bus.auto_reload && reload_q != '0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end else if (tick && count_q > ONE) begin
                count_d = count_q - ONE;
            end
        end else if (bus.start) begin
            if (state_q == DONE && reload_q != '0) begin
                count_d = reload_q;
                state_d = RUN;
            end else if (state_q == IDLE && count_q != '0) begin
                state_d = RUN;
            end
        end
    end

    // An acknowledge racing an expiry leaves irq set but never flags overflow.
    always_comb begin
        irq_d  = irq_q;
        ovf_d  = ovf_q;
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        if (bus.irq_ack) begin
            irq_d = expire;
            ovf_d = 1'b0;
        end else if (expire) begin
            irq_d = 1'b1;
            ovf_d = ovf_q | irq_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.irq   = irq_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - scoreboard bench for down_timer with directed scenarios and random traffic
module tb_down_timer;

    localparam int W = 16;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(W)) bus ();

    down_timer #(
        .WIDTH    (W),
        .PRESCALE (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        logic         irq;
        logic         ovf;
    } obs_t;

    obs_t exp_q[$];
    int   tag_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t got, want;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integers and flags describing the timer's behaviour.
    int m_count, m_reload, m_pre;
    bit m_run, m_done, m_irq, m_ovf;

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_pre = 0;
        m_run = 0; m_done = 0; m_irq = 0; m_ovf = 0;
    endtask

    task automatic model_step(bit ld, int lv, bit st, bit sp, bit ar, bit ack);
        bit expire;
        int eff;
        expire = 0;
        if (ld) begin
            m_reload = lv;
            m_count  = lv;
            m_pre    = 0;
            if (st && !m_run && lv != 0) begin
                m_run = 1; m_done = 0;
            end
        end else if (m_run) begin
            if (sp) begin
                m_run = 0; m_pre = 0;
            end else if (m_pre == P - 1) begin
                m_pre = 0;
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else if (m_count == 1) begin
                    expire = 1;
                    if (ar && m_reload != 0) begin
                        m_count = m_reload;
                    end else begin
                        m_count = 0; m_run = 0; m_done = 1;
                    end
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end else if (st) begin
            eff = m_done ? m_reload : m_count;
            if (eff != 0) begin
                m_count = eff; m_run = 1; m_done = 0;
            end
        end
        if (ack) begin
            m_irq = expire; m_ovf = 0;
        end else if (expire) begin
            m_ovf = m_ovf | m_irq;
            m_irq = 1;
        end
    endtask

    function automatic obs_t model_obs();
        return {W'(m_count), m_run, m_done, m_irq, m_ovf};
    endfunction

    task automatic drive(bit ld, int lv, bit st, bit sp, bit ar, bit ack);
        @(negedge clk);
        bus.load        = ld;
        bus.load_value  = W'(lv);
        bus.start       = st;
        bus.stop        = sp;
        bus.auto_reload = ar;
        bus.irq_ack     = ack;
        model_step(ld, lv, st, sp, ar, ack);
        exp_q.push_back(model_obs());
        tag_q.push_back(cyc + 1);
    endtask

    task automatic idle(bit ar);
        drive(0, 0, 0, 0, ar, 0);
    endtask

    task automatic check_zero(string name);
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.irq, bus.ovf} !== '0) begin
            errors++;
            $display("FAIL %s: got count=%0d busy=%b done=%b irq=%b ovf=%b, want all zero",
                     name, bus.count, bus.busy, bus.done, bus.irq, bus.ovf);
        end
    endtask

    // Monitor: every clock edge is an output event; compare against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (tag_q.size() > 0 && tag_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_stale: expectation for edge %0d not compared, now %0d", tag_q[0], cyc);
                void'(tag_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (tag_q.size() > 0 && tag_q[0] == cyc) begin
                void'(tag_q.pop_front());
                want = exp_q.pop_front();
                got  = {bus.count, bus.busy, bus.done, bus.irq, bus.ovf};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL edge%0d: got count=%0d busy=%b done=%b irq=%b ovf=%b, want count=%0d busy=%b done=%b irq=%b ovf=%b",
                             cyc, got.count, got.busy, got.done, got.irq, got.ovf,
                             want.count, want.busy, want.done, want.irq, want.ovf);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ld, st, sp, ack, ar_r;
        int lv;
        bus.load = 0; bus.load_value = '0; bus.start = 0;
        bus.stop = 0; bus.auto_reload = 0; bus.irq_ack = 0;
        model_reset();
        #1 rst = 1'b0;
        #2 check_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Load 0 with start: nothing runs.
        drive(1, 0, 1, 0, 0, 0);
        repeat (3) idle(0);

        // Single-shot countdown from 3.
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        repeat (9) idle(0);

        // Auto-reload from 2 without acknowledge: irq then ovf.
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 2, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        repeat (12) idle(1);

        // Stop exactly on the tick at count 4, then resume.
        drive(0, 0, 0, 1, 0, 1);
        drive(1, 5, 1, 0, 0, 0);
        for (int i = 0; i < 20 && !(m_run && m_count == 4 && m_pre == P - 1); i++) idle(0);
        drive(0, 0, 0, 1, 0, 0);
        repeat (3) idle(0);
        drive(0, 0, 1, 0, 0, 0);
        repeat (11) idle(0);

        // Acknowledge coincident with expiry while irq is already set.
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        idle(0);
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) idle(0);

        // Asynchronous reset mid-run at count 7.
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 9, 1, 0, 0, 0);
        for (int i = 0; i < 40 && m_count != 7; i++) idle(0);
        @(posedge clk);
        #2 rst = 1'b0;
        bus.load = 0; bus.start = 0; bus.stop = 0; bus.irq_ack = 0; bus.auto_reload = 0;
        #1 check_zero("async_reset");
        model_reset();
        exp_q.delete();
        tag_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        repeat (3) idle(0);

        // Random traffic against the model.
        ar_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ar_r = ~ar_r;
            ld  = ($urandom_range(0, 29) == 0);
            lv  = ($urandom_range(0, 99) == 0) ? 65535 : int'($urandom_range(0, 6));
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 19) == 0);
            drive(ld, lv, st, sp, ar_r, ack);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (tag_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, want 0", tag_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
